// File: rtl/fare_backend_arbiter_pkg.sv
// Shared types and constants for the fare-gate array: arbiter states,
// default sizing, and the display codes the gate FSMs drive.
package fare_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int N_GATES_DEFAULT = 4;
  localparam int TIMEOUT_DEFAULT = 15;

  localparam logic [1:0] DISP_IDLE      = 2'b00;
  localparam logic [1:0] DISP_INVALID   = 2'b01;
  localparam logic [1:0] DISP_LOW_FUNDS = 2'b10;
  localparam logic [1:0] DISP_OPEN      = 2'b11;

endpackage

// File: rtl/fare_backend_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first requesting gate
// at or after ptr, wrapping around the gate count.
module rr_pick
  import fare_pkg::*;
#(
  parameter int N_GATES = N_GATES_DEFAULT,
  parameter int ID_W    = $clog2(N_GATES)
) (
  input  logic [N_GATES-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  int pos;
  logic [ID_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit overwrites last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    cand  = '0;
    for (int i = N_GATES - 1; i >= 0; i--) begin
      pos = int'(ptr) + i;
      if (pos >= N_GATES) begin
        pos = pos - N_GATES;
      end
      cand = ID_W'(pos);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fare_backend_arbiter.sv
// Shares one fare-account backend among the station gates: round-robin
// grant, backend request/ack handshake with timeout, result return.
module fare_backend_arbiter
  import fare_pkg::*;
#(
  parameter int N_GATES = N_GATES_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int ID_W    = $clog2(N_GATES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               maintenance,
  input  logic [N_GATES-1:0] gate_req,
  output logic [N_GATES-1:0] gate_done,
  output logic               result_active,
  output logic               result_fund,
  output logic               backend_req,
  output logic [ID_W-1:0]    backend_gate_id,
  input  logic               backend_ack,
  input  logic               backend_active,
  input  logic               backend_fund,
  output logic               busy,
  output logic               timeout_err
);

  localparam int              CNT_W     = 8;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  LAST_GATE = ID_W'(N_GATES - 1);

  arb_state_t         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               backend_req_q, backend_req_d;
  logic [ID_W-1:0]    gate_id_q, gate_id_d;
  logic               result_active_q, result_active_d;
  logic               result_fund_q, result_fund_d;
  logic [N_GATES-1:0] gate_done_q, gate_done_d;
  logic               timeout_err_q, timeout_err_d;
  logic               busy_q, busy_d;

  logic               pick_valid;
  logic [ID_W-1:0]    pick_idx;

  rr_pick #(
    .N_GATES (N_GATES),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (gate_req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // gate_done/timeout_err are computed on the WAIT->RESP transition so the
  // registered pulse lands exactly in the RESP cycle.
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    cnt_d           = cnt_q;
    backend_req_d   = backend_req_q;
    gate_id_d       = gate_id_q;
    result_active_d = result_active_q;
    result_fund_d   = result_fund_q;
    gate_done_d     = '0;
    timeout_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!maintenance && pick_valid) begin
          gate_id_d     = pick_idx;
          backend_req_d = 1'b1;
          cnt_d         = '0;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        if (backend_ack) begin
          result_active_d        = backend_active;
          result_fund_d          = backend_fund;
          backend_req_d          = 1'b0;
          gate_done_d[gate_id_q] = 1'b1;
          state_d                = RESP;
        end else if (cnt_q == CNT_LAST) begin
          result_active_d        = 1'b0;
          result_fund_d          = 1'b0;
          backend_req_d          = 1'b0;
          gate_done_d[gate_id_q] = 1'b1;
          timeout_err_d          = 1'b1;
          state_d                = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        ptr_d   = (gate_id_q == LAST_GATE) ? '0 : gate_id_q + ID_W'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      cnt_q           <= '0;
      backend_req_q   <= 1'b0;
      gate_id_q       <= '0;
      result_active_q <= 1'b0;
      result_fund_q   <= 1'b0;
      gate_done_q     <= '0;
      timeout_err_q   <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      cnt_q           <= cnt_d;
      backend_req_q   <= backend_req_d;
      gate_id_q       <= gate_id_d;
      result_active_q <= result_active_d;
      result_fund_q   <= result_fund_d;
      gate_done_q     <= gate_done_d;
      timeout_err_q   <= timeout_err_d;
      busy_q          <= busy_d;
    end
  end

  assign gate_done       = gate_done_q;
  assign result_active   = result_active_q;
  assign result_fund     = result_fund_q;
  assign backend_req     = backend_req_q;
  assign backend_gate_id = gate_id_q;
  assign timeout_err     = timeout_err_q;
  assign busy            = busy_q;

endmodule
